// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: op classes, ALU functions, branch kinds
// and the multiplier state type.
package ex_stage_pkg;

    localparam logic [1:0] OP_REG = 2'b00;
    localparam logic [1:0] OP_IMM = 2'b01;
    localparam logic [1:0] OP_MEM = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    localparam logic [2:0] FUN_ADD = 3'b000;
    localparam logic [2:0] FUN_SUB = 3'b001;
    localparam logic [2:0] FUN_AND = 3'b010;
    localparam logic [2:0] FUN_OR  = 3'b011;
    localparam logic [2:0] FUN_XOR = 3'b100;
    localparam logic [2:0] FUN_SLT = 3'b101;
    localparam logic [2:0] FUN_SHL = 3'b110;
    localparam logic [2:0] FUN_MUL = 3'b111;

    localparam logic [1:0] JP_NONE = 2'b00;
    localparam logic [1:0] JP_BEQ  = 2'b01;
    localparam logic [1:0] JP_BNE  = 2'b10;
    localparam logic [1:0] JP_JMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } mulState_e;

    function automatic logic isMulOp(input logic [1:0] op, input logic [2:0] fun);
        return ((op == OP_REG) || (op == OP_IMM)) && (fun == FUN_MUL);
    endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, DATA_W cycles,
// then a single DONE cycle in which the low DATA_W bits of the product are valid.
module ex_mul_seq
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mulState_e         state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // Busy covers the accepting IDLE cycle as well, so the front end stalls at once.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy     = 1'b1;
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = CNT_W'(DATA_W);
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: ALU, branch resolution and the
// stalling multiplier, registering results for the MEM stage.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  ALU_a_EX,
    input  logic [DATA_W-1:0]  ALU_b_EX,
    input  logic [1:0]         op_EX,
    input  logic [2:0]         fun_EX,
    input  logic               ALU_mov_EX,
    input  logic [1:0]         jp_flag_EX,
    input  logic               wite_reg_EX,
    input  logic               wite_mem_EX,
    input  logic               read_mem_EX,
    input  logic [RADDR_W-1:0] addr3_EX,
    input  logic [DATA_W-1:0]  rt_EX,
    input  logic [PC_W-1:0]    Imm_EX,
    input  logic [1:0]         Mux3_EX,
    output logic [DATA_W-1:0]  alu_out_MEM,
    output logic [DATA_W-1:0]  rt_MEM,
    output logic [RADDR_W-1:0] addr3_MEM,
    output logic               wite_reg_MEM,
    output logic               wite_mem_MEM,
    output logic               read_mem_MEM,
    output logic [1:0]         Mux3_MEM,
    output logic               stall,
    output logic               br_taken,
    output logic [PC_W-1:0]    br_target
);

    localparam int SH_W = $clog2(DATA_W);

    logic              mulStart;
    logic              mulBusy;
    logic              mulDone;
    logic [DATA_W-1:0] mulProduct;
    logic [DATA_W-1:0] aluResult;
    logic              brCond;

    logic [DATA_W-1:0]  aluOut_q, aluOut_d;
    logic [DATA_W-1:0]  rt_q, rt_d;
    logic [RADDR_W-1:0] addr3_q, addr3_d;
    logic               wreg_q, wreg_d;
    logic               wmem_q, wmem_d;
    logic               rmem_q, rmem_d;
    logic [1:0]         mux3_q, mux3_d;

    assign mulStart = isMulOp(op_EX, fun_EX) && !reset;

    ex_mul_seq #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mulStart),
        .a      (ALU_a_EX),
        .b      (ALU_b_EX),
        .busy   (mulBusy),
        .done   (mulDone),
        .product(mulProduct)
    );

    assign stall = mulBusy && !reset;

    always_comb begin
        aluResult = ALU_a_EX + ALU_b_EX;
        if (ALU_mov_EX) begin
            aluResult = ALU_b_EX;
        end else if ((op_EX == OP_REG) || (op_EX == OP_IMM)) begin
            case (fun_EX)
                FUN_ADD: aluResult = ALU_a_EX + ALU_b_EX;
                FUN_SUB: aluResult = ALU_a_EX - ALU_b_EX;
                FUN_AND: aluResult = ALU_a_EX & ALU_b_EX;
                FUN_OR:  aluResult = ALU_a_EX | ALU_b_EX;
                FUN_XOR: aluResult = ALU_a_EX ^ ALU_b_EX;
                FUN_SLT: aluResult = {{(DATA_W-1){1'b0}}, ($signed(ALU_a_EX) < $signed(ALU_b_EX))};
                FUN_SHL: aluResult = ALU_a_EX << ALU_b_EX[SH_W-1:0];
                FUN_MUL: aluResult = mulProduct;
                default: aluResult = ALU_a_EX + ALU_b_EX;
            endcase
        end
    end

    always_comb begin
        brCond = 1'b0;
        case (jp_flag_EX)
            JP_BEQ:  brCond = (ALU_a_EX == ALU_b_EX);
            JP_BNE:  brCond = (ALU_a_EX != ALU_b_EX);
            JP_JMP:  brCond = 1'b1;
            default: brCond = 1'b0;
        endcase
    end

    assign br_taken  = brCond && !reset && !stall;
    assign br_target = Imm_EX;

    // While the multiplier runs the held instruction must not write anything yet;
    // its control is captured once, together with the product, in the DONE cycle.
    always_comb begin
        aluOut_d = mulDone ? mulProduct : aluResult;
        rt_d     = rt_EX;
        addr3_d  = addr3_EX;
        wreg_d   = wite_reg_EX;
        wmem_d   = wite_mem_EX;
        rmem_d   = read_mem_EX;
        mux3_d   = Mux3_EX;
        if (stall) begin
            wreg_d = 1'b0;
            wmem_d = 1'b0;
            rmem_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aluOut_q <= '0;
            rt_q     <= '0;
            addr3_q  <= '0;
            wreg_q   <= 1'b0;
            wmem_q   <= 1'b0;
            rmem_q   <= 1'b0;
            mux3_q   <= '0;
        end else begin
            aluOut_q <= aluOut_d;
            rt_q     <= rt_d;
            addr3_q  <= addr3_d;
            wreg_q   <= wreg_d;
            wmem_q   <= wmem_d;
            rmem_q   <= rmem_d;
            mux3_q   <= mux3_d;
        end
    end

    assign alu_out_MEM  = aluOut_q;
    assign rt_MEM       = rt_q;
    assign addr3_MEM    = addr3_q;
    assign wite_reg_MEM = wreg_q;
    assign wite_mem_MEM = wmem_q;
    assign read_mem_MEM = rmem_q;
    assign Mux3_MEM     = mux3_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed corner cases plus random instructions checked
// against an arithmetic reference model.
module tb_ex_stage;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int PC_W    = 8;

    logic               clk;
    logic               reset;
    logic [DATA_W-1:0]  ALU_a_EX;
    logic [DATA_W-1:0]  ALU_b_EX;
    logic [1:0]         op_EX;
    logic [2:0]         fun_EX;
    logic               ALU_mov_EX;
    logic [1:0]         jp_flag_EX;
    logic               wite_reg_EX;
    logic               wite_mem_EX;
    logic               read_mem_EX;
    logic [RADDR_W-1:0] addr3_EX;
    logic [DATA_W-1:0]  rt_EX;
    logic [PC_W-1:0]    Imm_EX;
    logic [1:0]         Mux3_EX;
    logic [DATA_W-1:0]  alu_out_MEM;
    logic [DATA_W-1:0]  rt_MEM;
    logic [RADDR_W-1:0] addr3_MEM;
    logic               wite_reg_MEM;
    logic               wite_mem_MEM;
    logic               read_mem_MEM;
    logic [1:0]         Mux3_MEM;
    logic               stall;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycleCount  = 0;

    ex_stage #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W),
        .PC_W   (PC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ALU_a_EX    (ALU_a_EX),
        .ALU_b_EX    (ALU_b_EX),
        .op_EX       (op_EX),
        .fun_EX      (fun_EX),
        .ALU_mov_EX  (ALU_mov_EX),
        .jp_flag_EX  (jp_flag_EX),
        .wite_reg_EX (wite_reg_EX),
        .wite_mem_EX (wite_mem_EX),
        .read_mem_EX (read_mem_EX),
        .addr3_EX    (addr3_EX),
        .rt_EX       (rt_EX),
        .Imm_EX      (Imm_EX),
        .Mux3_EX     (Mux3_EX),
        .alu_out_MEM (alu_out_MEM),
        .rt_MEM      (rt_MEM),
        .addr3_MEM   (addr3_MEM),
        .wite_reg_MEM(wite_reg_MEM),
        .wite_mem_MEM(wite_mem_MEM),
        .read_mem_MEM(read_mem_MEM),
        .Mux3_MEM    (Mux3_MEM),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result computed with plain integer arithmetic modulo 2^16.
    function automatic logic [15:0] refResult(input logic [1:0] op, input logic [2:0] fun,
                                              input logic mov, input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        longint r;
        if (mov) return b;
        if (op == 2'd2) return 16'((ua + ub) % 65536);
        case (fun)
            3'd0: r = (ua + ub) % 65536;
            3'd1: r = (ua - ub + 65536) % 65536;
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(a | b);
            3'd4: r = longint'(a ^ b);
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = (ua * (longint'(1) << (ub % 16))) % 65536;
            default: r = (ua * ub) % 65536;
        endcase
        return 16'(r);
    endfunction

    function automatic logic refBranch(input logic [1:0] jp, input logic [15:0] a, input logic [15:0] b);
        case (jp)
            2'd1:    return a == b;
            2'd2:    return a != b;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Presents one instruction, holds it through any stall, and checks its EX/MEM result.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [2:0] fun,
                                 input logic mov, input logic [1:0] jp,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic wr, input logic wm, input logic rm,
                                 input logic [2:0] dst, input logic [15:0] rtv,
                                 input logic [7:0] imm, input logic [1:0] mux,
                                 output int doneCycle);
        logic [15:0] expRes;
        logic        isMul;
        int          stallCycles;
        ALU_a_EX = a; ALU_b_EX = b; op_EX = op; fun_EX = fun; ALU_mov_EX = mov;
        jp_flag_EX = jp; wite_reg_EX = wr; wite_mem_EX = wm; read_mem_EX = rm;
        addr3_EX = dst; rt_EX = rtv; Imm_EX = imm; Mux3_EX = mux;
        #1;
        expRes = refResult(op, fun, mov, a, b);
        isMul  = (op < 2'd2) && (fun == 3'd7) && !mov;
        if (isMul) begin
            stallCycles = 0;
            while (stall === 1'b1 && stallCycles < 40) begin
                stallCycles++;
                @(posedge clk);
                #1;
                checkOutput({tag, "-bubble"}, 32'({wite_reg_MEM, wite_mem_MEM, read_mem_MEM}), 32'(0));
            end
            checkOutput({tag, "-stallcycles"}, 32'(stallCycles), 32'(DATA_W + 1));
        end else begin
            checkOutput({tag, "-stall"}, 32'(stall), 32'(0));
            checkOutput({tag, "-brtaken"}, 32'(br_taken), 32'(refBranch(jp, a, b)));
            if (jp != 2'd0) checkOutput({tag, "-brtarget"}, 32'(br_target), 32'(imm));
        end
        @(posedge clk);
        #1;
        doneCycle = cycleCount;
        if (op != 2'd3) checkOutput({tag, "-alu"}, 32'(alu_out_MEM), 32'(expRes));
        checkOutput({tag, "-rt"}, 32'(rt_MEM), 32'(rtv));
        checkOutput({tag, "-addr3"}, 32'(addr3_MEM), 32'(dst));
        checkOutput({tag, "-enables"}, 32'({wite_reg_MEM, wite_mem_MEM, read_mem_MEM}), 32'({wr, wm, rm}));
        checkOutput({tag, "-mux3"}, 32'(Mux3_MEM), 32'(mux));
    endtask

    initial begin
        int c1, c2, cx;
        logic [1:0]  rop, rjp;
        logic [2:0]  rfun, rdst;
        logic        rmov, rwr, rwm, rrm;
        logic [15:0] ra, rb, rrt;
        logic [7:0]  rimm;
        logic [1:0]  rmux;

        reset = 1'b1;
        ALU_a_EX = 16'd9; ALU_b_EX = 16'd9; op_EX = 2'd3; fun_EX = 3'd0; ALU_mov_EX = 1'b0;
        jp_flag_EX = 2'd3; wite_reg_EX = 1'b1; wite_mem_EX = 1'b1; read_mem_EX = 1'b1;
        addr3_EX = 3'd5; rt_EX = 16'h1234; Imm_EX = 8'h22; Mux3_EX = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset-alu", 32'(alu_out_MEM), 32'(0));
        checkOutput("reset-rt", 32'(rt_MEM), 32'(0));
        checkOutput("reset-addr3", 32'(addr3_MEM), 32'(0));
        checkOutput("reset-enables", 32'({wite_reg_MEM, wite_mem_MEM, read_mem_MEM}), 32'(0));
        checkOutput("reset-mux3", 32'(Mux3_MEM), 32'(0));
        checkOutput("reset-stall", 32'(stall), 32'(0));
        checkOutput("reset-brtaken", 32'(br_taken), 32'(0));
        reset = 1'b0;

        applyStimulus("add", 2'd0, 3'd0, 1'b0, 2'd0, 16'd5, 16'd7, 1'b1, 1'b0, 1'b0, 3'd3, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("sub", 2'd0, 3'd1, 1'b0, 2'd0, 16'd3, 16'd5, 1'b1, 1'b0, 1'b0, 3'd2, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("slt", 2'd0, 3'd5, 1'b0, 2'd0, 16'h8000, 16'd1, 1'b1, 1'b0, 1'b0, 3'd1, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("shl", 2'd1, 3'd6, 1'b0, 2'd0, 16'd1, 16'h0013, 1'b1, 1'b0, 1'b0, 3'd4, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("mul300x7", 2'd0, 3'd7, 1'b0, 2'd0, 16'd300, 16'd7, 1'b1, 1'b0, 1'b0, 3'd6, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("mulFFFFx2", 2'd0, 3'd7, 1'b0, 2'd0, 16'hFFFF, 16'd2, 1'b1, 1'b0, 1'b0, 3'd7, 16'd0, 8'd0, 2'd1, cx);
        applyStimulus("beq", 2'd3, 3'd0, 1'b0, 2'd1, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 8'h40, 2'd0, cx);
        applyStimulus("bne", 2'd3, 3'd0, 1'b0, 2'd2, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 8'h41, 2'd0, cx);
        applyStimulus("jump", 2'd3, 3'd0, 1'b0, 2'd3, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 8'h7F, 2'd0, cx);

        // Abandon a multiply by resetting during its fifth MUL cycle.
        ALU_a_EX = 16'd11; ALU_b_EX = 16'd13; op_EX = 2'd0; fun_EX = 3'd7; ALU_mov_EX = 1'b0;
        jp_flag_EX = 2'd0; wite_reg_EX = 1'b1; wite_mem_EX = 1'b0; read_mem_EX = 1'b0;
        addr3_EX = 3'd2; rt_EX = 16'd0; Imm_EX = 8'd0; Mux3_EX = 2'd1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midmul-stallbefore", 32'(stall), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_EX = 2'd0; fun_EX = 3'd0; wite_reg_EX = 1'b0;
        #1;
        checkOutput("midmul-stall", 32'(stall), 32'(0));
        checkOutput("midmul-wreg", 32'(wite_reg_MEM), 32'(0));
        checkOutput("midmul-alu", 32'(alu_out_MEM), 32'(0));
        applyStimulus("postreset-add", 2'd0, 3'd0, 1'b0, 2'd0, 16'd20, 16'd22, 1'b1, 1'b0, 1'b0, 3'd5, 16'd0, 8'd0, 2'd1, cx);

        applyStimulus("b2b-mul1", 2'd0, 3'd7, 1'b0, 2'd0, 16'd2, 16'd3, 1'b1, 1'b0, 1'b0, 3'd1, 16'd0, 8'd0, 2'd1, c1);
        applyStimulus("b2b-mul2", 2'd1, 3'd7, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 3'd2, 16'd0, 8'd0, 2'd1, c2);
        checkOutput("b2b-spacing", 32'(c2 - c1), 32'(DATA_W + 2));

        for (int i = 0; i < 150; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rfun = 3'($urandom_range(0, 7));
            rmov = ($urandom_range(0, 7) == 0);
            if (rmov && rfun == 3'd7) rfun = 3'd0;
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rdst = 3'($urandom);
            rrt  = 16'($urandom);
            rimm = 8'($urandom);
            rmux = 2'($urandom);
            if (rop == 2'd3) begin
                rjp = 2'($urandom_range(0, 3));
                rwr = 1'b0; rwm = 1'b0; rrm = 1'b0;
            end else begin
                rjp = 2'd0;
                rwr = 1'($urandom); rwm = 1'($urandom); rrm = 1'($urandom);
            end
            applyStimulus("rnd", rop, rfun, rmov, rjp, ra, rb, rwr, rwm, rrm, rdst, rrt, rimm, rmux, cx);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
